simon_pkt_out: RTL and testbench
================================

SIMON_PKT_OUT -- requirements
Module: simon_pkt_out

Interface
REQ-001 SHALL have parameter N, default 16: cipher word width in bits; multiple of 8.
REQ-002 SHALL have parameter BPP, default 2: blocks per packet, range 1..4; one block is 2N bits.
REQ-003 SHALL have parameter DEPTH, default 4: output packet FIFO entries; power of 2, at least 2.
REQ-004 SHALL have parameter MODE, default 0: expected mode value in info[3:0].
REQ-005 SHALL derive PW = 2 + BPP*N/4 as the packet width in bytes.
REQ-006 clk  in  1  sole clock; all state changes on its rising edge.
REQ-007 R  in  1  reset; synchronous, active-high.
REQ-008 in_valid  in  1  cipher core presents a block beat.
REQ-009 in_ready  out  1  block beat accepted when in_valid && in_ready.
REQ-010 in_info  in  8  packet header; sampled on the first beat only.
REQ-011 in_count  in  8  packet sequence number; sampled on the first beat only.
REQ-012 in_block  in  2N  cipher block {word1, word0}.
REQ-013 out_valid  out  1  FIFO head packet is valid.
REQ-014 out_ready  in  1  consumer pops the head when out_valid && out_ready.
REQ-015 out_pkt  out  PW*8  head packet, {info, count, slot0, slot1, ...}; info is the MS byte.
REQ-016 level  out  clog2(DEPTH)+1  FIFO occupancy.
REQ-017 err_count, err_mode, err_hdr  out  1 each  sticky error flags.
REQ-018 clr_err  in  1  clears all sticky error flags.

Function
REQ-019 SHALL use an FSM with states IDLE, COLLECT and PUSH.
REQ-020 IDLE, beat accepted: latch info and count; place in_block in slot0; clear remaining slots to 0.
REQ-021 IDLE exit: go to COLLECT if info[7]=1, info[5]=0 and BPP>1; otherwise go to PUSH.
REQ-022 COLLECT, k-th accepted beat (k=1..BPP-1): write in_block to slot k, ignoring in_info and in_count; after slot BPP-1 go to PUSH.
REQ-023 Key packet (info[5]=1): SHALL have all data slots forced to 0 and consume exactly one beat.
REQ-024 PUSH: write the assembled packet to the FIFO tail and return to IDLE; in_ready=0 during PUSH, giving one bubble per packet.
REQ-025 in_ready SHALL be 1 in IDLE and COLLECT only while level < DEPTH, so PUSH never meets a full FIFO.
REQ-026 Latency: last beat accepted at edge t; FIFO write at edge t+1; out_valid=1 in the cycle following edge t+1.
REQ-027 FIFO SHALL be first-in first-out; out_pkt shows the head while out_valid=1 and reads 0 when the FIFO is empty.
REQ-028 Simultaneous push and pop SHALL leave level unchanged and advance both pointers; pointer wrap at DEPTH SHALL be seamless.
REQ-029 Header checks SHALL run at header latch, with the expected count starting at 0.
REQ-030 Count check: in_count == expected gives expected+1; a mismatch sets err_count and resynchronises expected to in_count+1, mod 256.
REQ-031 in_info[3:0] != MODE SHALL set err_mode; in_info[4]=0 SHALL set err_hdr.
REQ-032 A packet with header errors SHALL still be assembled and emitted unchanged.
REQ-033 clr_err clears all error flags; if an error event coincides with clr_err, the set wins.
REQ-034 Deasserting in_valid mid-packet SHALL stall COLLECT indefinitely without losing assembled slots.

Reset
REQ-035 While R=1, the block SHALL have: state=IDLE, FIFO empty, level=0, out_valid=0, out_pkt=0, in_ready=0, expected count=0, all error flags=0.
REQ-036 R asserted mid-packet or with a non-empty FIFO SHALL discard the partial packet and all FIFO contents; no packet is emitted.
REQ-037 in_ready SHALL rise on the first cycle after R deasserts.

Verification (N=16, BPP=2, DEPTH=4, MODE=0)
REQ-038 Full packet: beat1 info=0x90, count=0x00, block=0xAAAABBBB; beat2 block=0x11112222 -> out_pkt=0x90_00_AAAABBBB_11112222, out_valid 2 cycles after beat2, no errors.
REQ-039 Single block: info=0x10, count=0x01, block=0x12345678 -> out_pkt=0x10_01_12345678_00000000, one beat consumed.
REQ-040 Key packet: info=0x30, count=0x02, block=0xDEADBEEF -> out_pkt=0x30_02_00000000_00000000.
REQ-041 Errors: count=0x05 when 0x03 expected -> err_count=1; the next packet with count 0x06 raises no new error; info=0x01 -> err_mode=1 and err_hdr=1.
REQ-042 Backpressure: out_ready=0, five single-block packets sent -> level=4 and in_ready=0 with the fifth beat held; out_ready=1 -> four packets drain in order, then the fifth is accepted and emitted.
REQ-043 R=1 after beat1 of a full packet -> level=0, out_valid=0, expected count=0; the next packet with count 0x00 raises no error.

Source files
------------

// File: rtl/simon_pkt_out.sv
// Packs cipher-core output blocks into {info, count, slots} packets and queues them in a small FIFO.
// Header fields are checked against a running sequence number and the expected mode; errors are sticky.
module simon_pkt_out #(
    parameter int N     = 16,
    parameter int BPP   = 2,
    parameter int DEPTH = 4,
    parameter int MODE  = 0,
    localparam int PW   = 2 + BPP * N / 4,
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              R,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_info,
    input  logic [7:0]        in_count,
    input  logic [2*N-1:0]    in_block,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PW*8-1:0]   out_pkt,
    output logic [LW-1:0]     level,
    output logic              err_count,
    output logic              err_mode,
    output logic              err_hdr,
    input  logic              clr_err
);
    localparam int PKT_W = PW * 8;
    localparam int BW    = 2 * N;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
    localparam logic [3:0]    MODE_NIB = 4'(MODE);
    localparam logic [1:0]    LAST     = 2'(BPP - 1);
    localparam bit            MULTI    = (BPP > 1);

    typedef enum logic [1:0] {IDLE, COLLECT, PUSH} state_t;

    state_t            state_reg, state_next;
    logic [1:0]        beat_reg;
    logic [7:0]        info_reg, count_reg, exp_reg;
    logic              err_count_reg, err_mode_reg, err_hdr_reg;
    logic [PKT_W-1:0]  pkt_asm;
    logic [PKT_W-1:0]  mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [LW-1:0]     level_reg;

    logic accept, push, pop, room, hdr_latch;
    logic cnt_bad, mode_bad, hdr_bad;

    assign room      = level_reg < DEPTH_L;
    assign accept    = in_valid && in_ready;
    assign hdr_latch = (state_reg == IDLE) && accept;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (R) state_reg <= IDLE;
        else   state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept)
                    state_next = (in_info[7] && !in_info[5] && MULTI) ? COLLECT : PUSH;
            end
            COLLECT: begin
                if (accept && beat_reg == LAST)
                    state_next = PUSH;
            end
            PUSH:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        push     = 1'b0;
        case (state_reg)
            IDLE, COLLECT: in_ready = room && !R;
            PUSH:          push     = 1'b1;
            default:       ;
        endcase
    end

    // ---------------- packet assembly ----------------
    always_ff @(posedge clk) begin
        if (R) begin
            beat_reg  <= '0;
            info_reg  <= '0;
            count_reg <= '0;
        end else if (hdr_latch) begin
            beat_reg  <= 2'd1;
            info_reg  <= in_info;
            count_reg <= in_count;
        end else if (state_reg == COLLECT && accept) begin
            beat_reg  <= beat_reg + 2'd1;
        end
    end

    assign pkt_asm[PKT_W-1 -: 16] = {info_reg, count_reg};

    genvar gi;
    generate
        for (gi = 0; gi < BPP; gi++) begin : g_slot
            logic [BW-1:0] slot_reg;
            // Header beat fills slot0 (zero for key packets) and wipes every later slot.
            always_ff @(posedge clk) begin
                if (R)
                    slot_reg <= '0;
                else if (hdr_latch)
                    slot_reg <= (gi == 0 && !in_info[5]) ? in_block : '0;
                else if (state_reg == COLLECT && accept && beat_reg == 2'(gi))
                    slot_reg <= in_block;
            end
            assign pkt_asm[(BPP-gi)*BW-1 -: BW] = slot_reg;
        end
    endgenerate

    // ---------------- header checks ----------------
    assign cnt_bad  = hdr_latch && (in_count != exp_reg);
    assign mode_bad = hdr_latch && (in_info[3:0] != MODE_NIB);
    assign hdr_bad  = hdr_latch && !in_info[4];

    always_ff @(posedge clk) begin
        if (R) begin
            exp_reg       <= '0;
            err_count_reg <= 1'b0;
            err_mode_reg  <= 1'b0;
            err_hdr_reg   <= 1'b0;
        end else begin
            // Match or mismatch, the next expected number follows the received one.
            if (hdr_latch)
                exp_reg <= in_count + 8'd1;
            err_count_reg <= cnt_bad  || (err_count_reg && !clr_err);
            err_mode_reg  <= mode_bad || (err_mode_reg  && !clr_err);
            err_hdr_reg   <= hdr_bad  || (err_hdr_reg   && !clr_err);
        end
    end

    assign err_count = err_count_reg;
    assign err_mode  = err_mode_reg;
    assign err_hdr   = err_hdr_reg;

    // ---------------- output FIFO ----------------
    assign pop = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (push && !R)
            mem[wr_ptr_reg] <= pkt_asm;
    end

    always_ff @(posedge clk) begin
        if (R) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    assign out_valid = (level_reg != '0) && !R;
    assign out_pkt   = out_valid ? mem[rd_ptr_reg] : '0;
    assign level     = level_reg;

endmodule

// File: tb/tb_simon_pkt_out.sv
// Directed bench for simon_pkt_out (N=16, BPP=2, DEPTH=4, MODE=0): vector table plus
// hand-written backpressure and reset sequences.
module tb_simon_pkt_out;
    logic        clk;
    logic        R;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_info;
    logic [7:0]  in_count;
    logic [31:0] in_block;
    logic        out_valid;
    logic        out_ready;
    logic [79:0] out_pkt;
    logic [2:0]  level;
    logic        err_count, err_mode, err_hdr;
    logic        clr_err;

    int checks = 0;
    int errors = 0;

    simon_pkt_out #(.N(16), .BPP(2), .DEPTH(4), .MODE(0)) dut (
        .clk(clk), .R(R),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_info(in_info), .in_count(in_count), .in_block(in_block),
        .out_valid(out_valid), .out_ready(out_ready), .out_pkt(out_pkt),
        .level(level),
        .err_count(err_count), .err_mode(err_mode), .err_hdr(err_hdr),
        .clr_err(clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  info;
        logic [7:0]  count;
        logic [31:0] b0;
        logic [31:0] b1;
        int          beats;
        int          gap;   // idle cycles between beat 1 and beat 2
        int          clr;   // 0 none, 1 pulse before packet, 2 held during header beat
        logic [79:0] pkt;
        logic [2:0]  errs;  // {err_count, err_mode, err_hdr}
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] info, input logic [7:0] count, input logic [31:0] blk);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_info  = info;
        in_count = count;
        in_block = blk;
        for (int c = 0; c < 100; c++) begin
            if (in_ready) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        if (!ok) chk("beat_accept_timeout", 80'd0, 80'd1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int n;
        if (v.clr == 1) begin
            clr_err = 1'b1;
            tick();
            clr_err = 1'b0;
        end
        clr_err = (v.clr == 2);
        send_beat(v.info, v.count, v.b0);
        clr_err = 1'b0;
        if (v.beats == 2) begin
            if (v.gap > 0) begin
                repeat (v.gap) tick();
                chk("stall_no_output", {78'd0, out_valid, in_ready}, 80'd1);
            end
            // Garbage header fields on the second beat must be ignored.
            send_beat(8'hFF, 8'hEE, v.b1);
        end
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("latency", 80'(n), 80'd1);
        chk("pkt", out_pkt, v.pkt);
        chk("errs", {77'd0, err_count, err_mode, err_hdr}, {77'd0, v.errs});
        $display("vec %0d: info=%h count=%h pkt=%h errs=%b%b%b lat=%0d",
                 idx, v.info, v.count, out_pkt, err_count, err_mode, err_hdr, n);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("empty_after_pop", {77'd0, level}, 80'd0);
        chk("pkt_zero_when_empty", out_pkt, 80'd0);
    endtask

    logic [79:0] bp_exp [5];
    bit          pending;

    initial begin
        vecs[0]  = '{8'h90, 8'h00, 32'hAAAABBBB, 32'h11112222, 2, 0, 0, 80'h90_00_AAAABBBB_11112222, 3'b000};
        vecs[1]  = '{8'h10, 8'h01, 32'h12345678, 32'h0,        1, 0, 0, 80'h10_01_12345678_00000000, 3'b000};
        vecs[2]  = '{8'h30, 8'h02, 32'hDEADBEEF, 32'h0,        1, 0, 0, 80'h30_02_00000000_00000000, 3'b000};
        vecs[3]  = '{8'h10, 8'h05, 32'hCAFEF00D, 32'h0,        1, 0, 0, 80'h10_05_CAFEF00D_00000000, 3'b100};
        vecs[4]  = '{8'h10, 8'h06, 32'h01020304, 32'h0,        1, 0, 1, 80'h10_06_01020304_00000000, 3'b000};
        vecs[5]  = '{8'h01, 8'h07, 32'h55556666, 32'h0,        1, 0, 0, 80'h01_07_55556666_00000000, 3'b011};
        vecs[6]  = '{8'hB0, 8'h08, 32'h77778888, 32'h0,        1, 0, 1, 80'hB0_08_00000000_00000000, 3'b000};
        vecs[7]  = '{8'h90, 8'h09, 32'h13572468, 32'h9ABCDEF0, 2, 5, 0, 80'h90_09_13572468_9ABCDEF0, 3'b000};
        vecs[8]  = '{8'h10, 8'h20, 32'h0F0F0F0F, 32'h0,        1, 0, 2, 80'h10_20_0F0F0F0F_00000000, 3'b100};
        vecs[9]  = '{8'h82, 8'h21, 32'h11223344, 32'h55667788, 2, 0, 1, 80'h82_21_11223344_55667788, 3'b011};
        vecs[10] = '{8'h10, 8'hFF, 32'hA5A5A5A5, 32'h0,        1, 0, 1, 80'h10_FF_A5A5A5A5_00000000, 3'b100};
        vecs[11] = '{8'h10, 8'h00, 32'h5A5A5A5A, 32'h0,        1, 0, 1, 80'h10_00_5A5A5A5A_00000000, 3'b000};

        R = 1'b1; in_valid = 1'b0; in_info = '0; in_count = '0; in_block = '0;
        out_ready = 1'b0; clr_err = 1'b0;
        repeat (3) tick();
        chk("rst_level", {77'd0, level}, 80'd0);
        chk("rst_out_valid", {79'd0, out_valid}, 80'd0);
        chk("rst_out_pkt", out_pkt, 80'd0);
        chk("rst_in_ready", {79'd0, in_ready}, 80'd0);
        chk("rst_errs", {77'd0, err_count, err_mode, err_hdr}, 80'd0);
        R = 1'b0;
        #1;
        chk("in_ready_after_rst", {79'd0, in_ready}, 80'd1);
        tick();

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Backpressure: four packets fill the FIFO, the fifth beat must wait.
        for (int k = 0; k < 5; k++)
            bp_exp[k] = {8'h10, 8'(k + 1), 32'(k + 1), 32'h0};
        for (int k = 0; k < 4; k++)
            send_beat(8'h10, 8'(k + 1), 32'(k + 1));
        repeat (2) tick();
        chk("bp_level_full", {77'd0, level}, 80'd4);
        in_valid = 1'b1; in_info = 8'h10; in_count = 8'h05; in_block = 32'h5;
        repeat (3) begin
            chk("bp_in_ready_low", {79'd0, in_ready}, 80'd0);
            tick();
        end
        chk("bp_level_held", {77'd0, level}, 80'd4);
        out_ready = 1'b1;
        pending = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", {79'd0, out_valid}, 80'd1);
            chk("bp_pkt", out_pkt, bp_exp[k]);
            $display("drain %0d: pkt=%h level=%0d", k, out_pkt, level);
            if (in_valid && in_ready) pending = 1'b1;
            tick();
            if (pending) in_valid = 1'b0;
        end
        out_ready = 1'b0;
        chk("bp_fifth_accepted", {79'd0, pending}, 80'd1);
        chk("bp_drained", {77'd0, level}, 80'd0);
        chk("bp_errs", {77'd0, err_count, err_mode, err_hdr}, 80'd0);

        // Reset with one queued packet and a half-built packet.
        send_beat(8'h10, 8'h06, 32'hCCCCCCCC);
        send_beat(8'h90, 8'h07, 32'hDDDDDDDD);
        chk("pre_rst_level", {77'd0, level}, 80'd1);
        R = 1'b1;
        tick();
        chk("mid_rst_level", {77'd0, level}, 80'd0);
        chk("mid_rst_valid", {79'd0, out_valid}, 80'd0);
        chk("mid_rst_pkt", out_pkt, 80'd0);
        chk("mid_rst_in_ready", {79'd0, in_ready}, 80'd0);
        R = 1'b0;
        #1;
        chk("post_rst_in_ready", {79'd0, in_ready}, 80'd1);
        repeat (4) tick();
        chk("post_rst_no_pkt", {78'd0, out_valid, level != 3'd0}, 80'd0);
        $display("reset: level=%0d out_valid=%b", level, out_valid);
        run_vec(12, '{8'h10, 8'h00, 32'h87654321, 32'h0, 1, 0, 0, 80'h10_00_87654321_00000000, 3'b000});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
